apb_uart_fifo: RTL and testbench
================================

# apb_uart_fifo

APB3 register front-end for the UART byte engines, generalised from the single-register bridge to parameterised data width with buffered TX and RX FIFOs. Adds sticky error flags and a maskable interrupt. Sits between the APB interconnect and the UART serializer/deserializer. CPU writes are queued and drained to the serializer over a valid/ready handshake. Received characters are queued until the CPU reads them.

## Interface
- DATA_W, 8, character width, legal 5..9
- TX_DEPTH, 16, TX FIFO entries, power of 2, 2..128
- RX_DEPTH, 16, RX FIFO entries, power of 2, 2..128
- PCLK  in  1  clock
- PRESETn  in  1  reset: asynchronous, active-low; clock is PCLK
- PSEL  in  1  slave select
- PADDR  in  [11:2]  word address
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write
- PWDATA  in  32  write data
- PRDATA  out  32  read data, valid in access phase
- PREADY  out  1  constant 1, zero wait states
- PSLVERR  out  1  error response, access phase only
- tx_data  out  DATA_W  TX FIFO head
- tx_valid  out  1  head valid for serializer
- tx_ready  in  1  serializer accepts head this cycle
- rx_data  in  DATA_W  received character
- rx_valid  in  1  one-cycle strobe, rx_data valid
- irq  out  1  level interrupt, registered

## Operation
- Access condition: PSEL & PENABLE. All register side effects occur on that cycle only. The setup phase has no effect.
- Register offset is PADDR[3:2]. Any access with PADDR[11:4] != 0 is unmapped: PRDATA = 0, PSLVERR = 1, no side effect.
- 0x0 DATA write: pushes PWDATA[DATA_W-1:0] into TX FIFO.
  - If the TX FIFO is full and tx_valid & tx_ready is not true that cycle, the character is dropped and tx_overflow is set.
- 0x0 DATA read:
  - RX not empty: returns {1'b0, zeros, head}, i.e. bit31 = 0 and head in [DATA_W-1:0]. The head is popped.
  - RX empty: returns 0x8000_0000. No pop.
- 0x4 STATUS, read-only; writes are ignored with PSLVERR 0. Fields:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty
  - [4] rx_overrun, [5] tx_overflow
  - [15:8] tx_count, [23:16] rx_count; other bits 0.
- 0x8 CTRL, RW, bits [4:0]: tx_en, rx_en, irq_rx_en, irq_tx_en, irq_err_en. Reset value 0x03. Other bits read 0.
- 0xC CLEAR, write-only, reads 0. Write-1 bits:
  - [0] flush TX, [1] flush RX
  - [2] clear rx_overrun, [3] clear tx_overflow
- TX drain: tx_valid = tx_en & !tx_empty, and tx_data = head. A pop occurs when tx_valid & tx_ready. Clearing tx_en holds the FIFO contents.
- RX fill: on rx_valid & rx_en, rx_data is pushed.
  - RX full with no CPU pop the same cycle: character dropped, rx_overrun set.
  - rx_valid while rx_en = 0: ignored, no flag.
- Sticky flags stay set until cleared via CLEAR. A set and a clear in the same cycle: set wins.
- irq is the registered value of (irq_rx_en & !rx_empty) | (irq_tx_en & tx_empty) | (irq_err_en & (rx_overrun | tx_overflow)).
- FIFOs: circular buffers with wrapping pointers and a count of width $clog2(DEPTH)+1, so full is distinguished from empty.

## Timing
- Reset values: PRDATA 0, PSLVERR 0, PREADY 1, tx_valid 0, irq 0, FIFOs empty, flags 0, CTRL 0x03.
- PRDATA and PSLVERR are combinational from the access-phase inputs, and 0 outside an access phase.
- A character written at edge N has tx_valid = 1 after edge N when the FIFO was empty and tx_en = 1.
- An rx_valid strobe at edge N sets rx_empty = 0 after edge N. It is readable by an access whose access phase is at cycle N+1 or later.
- irq lags the flag change by one cycle.
- Simultaneous events:
  - Push and pop on the same cycle: count unchanged. This is allowed when the FIFO is full (push accepted) and when it is empty only for the RX path with pop-first semantics. An empty read returns 0x8000_0000 and the pushed character is stored.
  - A flush in the same cycle as a push discards that push. The count is 0 after the edge and no flag is set.
- Asynchronous reset mid-operation empties both FIFOs immediately and deasserts tx_valid and irq without waiting for a clock.

## Test plan
- Reset, then read STATUS -> 0x0000_000A; read CTRL -> 0x03; read DATA -> 0x8000_0000.
- Hold tx_ready = 0 and write 0x41, 0x42, 0x43. STATUS -> tx_count = 3; tx_data = 0x41. Then set tx_ready = 1 -> 0x41, 0x42, 0x43 drain on consecutive cycles and tx_empty = 1.
- TX_DEPTH = 16 with tx_ready = 0: write 17 characters -> tx_count = 16, tx_overflow = 1. Write CLEAR = 0x8 -> tx_overflow = 0.
- Strobe rx_valid 17 times with 0x00..0x10 -> rx_overrun = 1. DATA reads return 0x00..0x0F, then 0x8000_0000.
- Set CTRL = 0x07 and strobe rx_valid with 0x55 -> irq rises one cycle after rx_empty falls. Read DATA -> 0x55, and irq falls one cycle later.
- Access PADDR = 0x010 -> PSLVERR = 1 and PRDATA = 0. Write CLEAR = 0x1 coincident with a DATA write -> tx_count = 0.

Source files
------------

// File: rtl/apb_uart_fifo.sv
// APB3 register front-end for the UART byte engines: buffered TX/RX FIFOs,
// sticky error flags and a registered, maskable interrupt.

module apb_uart_fifo_buf #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
  assign do_pop  = pop_i & !empty_o & !flush_i;
  assign do_push = push_i & !flush_i & (!full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module apb_uart_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic [11:2]       PADDR,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              irq
);
  localparam int unsigned TCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RX_DEPTH) + 1;

  logic              access, mapped, wr_data, rd_data, wr_ctrl, wr_clear;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop, flush_tx, flush_rx;
  logic [TCW-1:0]    tx_count;
  logic [RCW-1:0]    rx_count;
  logic [DATA_W-1:0] rx_head;
  logic [31:0]       status;
  logic [4:0]        ctrl_q, ctrl_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_overflow_q, tx_overflow_d;
  logic              irq_q, irq_d;
  logic              unused_pwdata;

  assign unused_pwdata = ^PWDATA;

  assign access   = PSEL & PENABLE;
  assign mapped   = (PADDR[11:4] == '0);
  assign wr_data  = access & mapped &  PWRITE & (PADDR[3:2] == 2'd0);
  assign rd_data  = access & mapped & !PWRITE & (PADDR[3:2] == 2'd0);
  assign wr_ctrl  = access & mapped &  PWRITE & (PADDR[3:2] == 2'd2);
  assign wr_clear = access & mapped &  PWRITE & (PADDR[3:2] == 2'd3);

  assign flush_tx = wr_clear & PWDATA[0];
  assign flush_rx = wr_clear & PWDATA[1];
  assign tx_push  = wr_data;
  assign tx_valid = ctrl_q[0] & !tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & ctrl_q[1];
  assign rx_pop   = rd_data & !rx_empty;

  apb_uart_fifo_buf #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(PCLK), .rst_ni(PRESETn), .flush_i(flush_tx), .push_i(tx_push),
    .pop_i(tx_pop), .data_i(PWDATA[DATA_W-1:0]), .head_o(tx_data),
    .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty)
  );

  apb_uart_fifo_buf #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(PCLK), .rst_ni(PRESETn), .flush_i(flush_rx), .push_i(rx_push),
    .pop_i(rx_pop), .data_i(rx_data), .head_o(rx_head),
    .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
  );

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[4]     = rx_overrun_q;
    status[5]     = tx_overflow_q;
    status[15:8]  = 8'(tx_count);
    status[23:16] = 8'(rx_count);
  end

  always_comb begin
    PRDATA  = '0;
    PSLVERR = access & !mapped;
    if (access & mapped & !PWRITE) begin
      case (PADDR[3:2])
        2'd0:    PRDATA = rx_empty ? 32'h8000_0000 : 32'(rx_head);
        2'd1:    PRDATA = status;
        2'd2:    PRDATA = {27'b0, ctrl_q};
        default: PRDATA = '0;
      endcase
    end
  end

  // Clears are applied first so a same-cycle set wins.
  always_comb begin
    ctrl_d        = ctrl_q;
    rx_overrun_d  = rx_overrun_q;
    tx_overflow_d = tx_overflow_q;
    if (wr_ctrl) ctrl_d = PWDATA[4:0];
    if (wr_clear & PWDATA[2]) rx_overrun_d  = 1'b0;
    if (wr_clear & PWDATA[3]) tx_overflow_d = 1'b0;
    if (rx_push & rx_full & !rx_pop & !flush_rx) rx_overrun_d  = 1'b1;
    if (tx_push & tx_full & !tx_pop & !flush_tx) tx_overflow_d = 1'b1;
    irq_d = (ctrl_q[2] & !rx_empty) | (ctrl_q[3] & tx_empty) |
            (ctrl_q[4] & (rx_overrun_q | tx_overflow_q));
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q        <= 5'h03;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
      irq_q         <= irq_d;
    end
  end

  assign irq    = irq_q;
  assign PREADY = 1'b1;
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed testbench for apb_uart_fifo (DATA_W=8, 16-deep FIFOs).

module tb_apb_uart_fifo;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:2] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        irq;

  int unsigned tests = 0, fails = 0;
  logic        acc_tx_ready = 1'b0, acc_rx_valid = 1'b0;
  logic [7:0]  acc_rx_data = '0;
  logic [31:0] r;
  logic        e;

  always #5 PCLK = ~PCLK;

  apb_uart_fifo #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Optional tx_ready / rx_valid pulses are applied only in the access phase.
  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a[11:2]; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (acc_rx_valid) begin rx_valid = 1'b1; rx_data = acc_rx_data; end
    if (acc_tx_ready) tx_ready = 1'b1;
    @(negedge PCLK);
    rd = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
    if (acc_tx_ready) tx_ready = 1'b0;
    acc_tx_ready = 1'b0; acc_rx_valid = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] rr; logic ee;
    apb(1'b1, a, d, rr, ee);
  endtask

  task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] rr; logic ee;
    apb(1'b0, a, '0, rr, ee);
    check(tag, rr, exp);
  endtask

  initial begin
    #2;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_pready", {31'b0, PREADY}, 32'h1);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    #13 PRESETn = 1'b1;

    rdchk("status_rst", 12'h004, 32'h0000_000A);
    rdchk("ctrl_rst", 12'h008, 32'h0000_0003);
    rdchk("data_empty", 12'h000, 32'h8000_0000);

    // TX held, then drained on consecutive cycles
    wr(12'h000, 32'h41); wr(12'h000, 32'h42); wr(12'h000, 32'h43);
    rdchk("status_tx3", 12'h004, 32'h0000_0308);
    check("tx_head", {24'b0, tx_data}, 32'h41);
    check("tx_valid_held", {31'b0, tx_valid}, 32'h1);
    @(posedge PCLK); #1 tx_ready = 1'b1;
    @(negedge PCLK); check("drain0", {23'b0, tx_valid, tx_data}, 32'h141);
    @(negedge PCLK); check("drain1", {23'b0, tx_valid, tx_data}, 32'h142);
    @(negedge PCLK); check("drain2", {23'b0, tx_valid, tx_data}, 32'h143);
    @(negedge PCLK); check("drain_done", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rdchk("status_tx_empty", 12'h004, 32'h0000_000A);

    // TX overflow at 17 writes, flag clear, full push+pop, flush
    for (int i = 0; i < 17; i++) wr(12'h000, 32'(i));
    rdchk("status_tx_ovf", 12'h004, 32'h0000_1029);
    wr(12'h00C, 32'h8);
    rdchk("status_ovf_clr", 12'h004, 32'h0000_1009);
    acc_tx_ready = 1'b1;
    wr(12'h000, 32'h99);
    rdchk("status_full_pushpop", 12'h004, 32'h0000_1009);
    check("tx_head_after_pop", {24'b0, tx_data}, 32'h01);
    wr(12'h00C, 32'h1);
    rdchk("status_tx_flush", 12'h004, 32'h0000_000A);

    // RX overrun
    for (int i = 0; i < 17; i++) begin
      @(posedge PCLK); #1 rx_valid = 1'b1; rx_data = 8'(i);
    end
    @(posedge PCLK); #1 rx_valid = 1'b0;
    rdchk("status_rx_ovr", 12'h004, 32'h0010_0016);
    for (int i = 0; i < 16; i++) rdchk($sformatf("rx_read%0d", i), 12'h000, 32'(i));
    rdchk("rx_read_empty", 12'h000, 32'h8000_0000);
    wr(12'h00C, 32'h4);
    rdchk("status_ovr_clr", 12'h004, 32'h0000_000A);

    // irq follows rx_empty with one cycle lag
    wr(12'h008, 32'h07);
    rdchk("ctrl_07", 12'h008, 32'h0000_0007);
    check("irq_idle", {31'b0, irq}, 32'h0);
    @(posedge PCLK); #1 rx_valid = 1'b1; rx_data = 8'h55;
    @(posedge PCLK); #1 rx_valid = 1'b0;
    check("irq_lag", {31'b0, irq}, 32'h0);
    @(posedge PCLK); #1;
    check("irq_rise", {31'b0, irq}, 32'h1);
    rdchk("rx_55", 12'h000, 32'h55);
    check("irq_hold", {31'b0, irq}, 32'h1);
    @(posedge PCLK); #1;
    check("irq_fall", {31'b0, irq}, 32'h0);

    // empty-read with simultaneous push stores the character
    acc_rx_valid = 1'b1; acc_rx_data = 8'h66;
    rdchk("rx_pushpop_empty", 12'h000, 32'h8000_0000);
    rdchk("status_rx1", 12'h004, 32'h0001_0002);
    rdchk("rx_66", 12'h000, 32'h66);

    // flush with simultaneous push, and rx_en=0
    acc_rx_valid = 1'b1; acc_rx_data = 8'h77;
    wr(12'h00C, 32'h2);
    rdchk("status_rx_flush_push", 12'h004, 32'h0000_000A);
    wr(12'h008, 32'hFFFF_FFFF);
    rdchk("ctrl_mask", 12'h008, 32'h0000_001F);
    wr(12'h008, 32'h01);
    @(posedge PCLK); #1 rx_valid = 1'b1; rx_data = 8'h12;
    @(posedge PCLK); #1 rx_valid = 1'b0;
    rdchk("status_rx_dis", 12'h004, 32'h0000_000A);

    // unmapped and read-only accesses
    apb(1'b0, 12'h010, '0, r, e);
    check("unmapped_prdata", r, 32'h0);
    check("unmapped_pslverr", {31'b0, e}, 32'h1);
    apb(1'b1, 12'h004, 32'hFFFF_FFFF, r, e);
    check("status_wr_pslverr", {31'b0, e}, 32'h0);
    rdchk("clear_reads0", 12'h00C, 32'h0);

    // asynchronous reset mid-operation
    wr(12'h008, 32'h07);
    @(posedge PCLK); #1 rx_valid = 1'b1; rx_data = 8'h33;
    @(posedge PCLK); #1 rx_valid = 1'b0;
    wr(12'h000, 32'h11);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    check("pre_rst_tx_valid", {31'b0, tx_valid}, 32'h1);
    #2 PRESETn = 1'b0;
    #1;
    check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("async_irq", {31'b0, irq}, 32'h0);
    @(negedge PCLK) PRESETn = 1'b1;
    rdchk("status_after_rst", 12'h004, 32'h0000_000A);
    rdchk("ctrl_after_rst", 12'h008, 32'h0000_0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
